key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_pkg.sv | 30 +++
 rtl/key_debounce_ch.sv | 129 ++++++++++++
 rtl/key_debounce.sv | 36 +++
 tb/tb_key_debounce.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and default timing for the key debouncer.
// Optional feature macro: KEY_DEBOUNCE_REPEAT_EN (auto-repeat on held keys).
package key_debounce_pkg;

  // Per-channel debounce FSM, 2-bit encoding.
  typedef enum logic [1:0] {
    KEY_RELEASED     = 2'd0,
    KEY_PRESS_WAIT   = 2'd1,
    KEY_HELD         = 2'd2,
    KEY_RELEASE_WAIT = 2'd3
  } key_state_t;

  // Default timing, 50 MHz board clock.
  localparam int DEF_NUM_KEYS        = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms
  localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms
  localparam int DEF_REPEAT_PERIOD   = 10000000;  // 200 ms

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One counter width covers stability and repeat timing.
  function automatic int cnt_width(input int db, input int rd, input int rp);
    return $clog2(max3(db, rd, rp) + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced push-button channel: 2-flop synchronizer, 4-state debounce
// FSM, registered level/press/release outputs.
// Optional feature macro: KEY_DEBOUNCE_REPEAT_EN adds an auto-repeat timer
// that re-pulses press_pulse while the key stays held.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_lvl,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  // Terminal count: the edge that sees the counter at DB_LAST is the
  // DEBOUNCE_CYCLES-th stable edge and commits the new level.
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          key_s;
  key_state_t    state;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer; idles high (released) out of reset.
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], key_raw};
  end

  assign key_s = sync[1];

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  logic [CW-1:0] rpt_cnt;
  logic          rpt_first;   // still waiting for the long initial delay
`endif

  // Debounce FSM with registered outputs; counter stops at the terminal
  // value instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= KEY_RELEASED;
      cnt           <= '0;
      key_lvl       <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
      rpt_cnt       <= '0;
      rpt_first     <= 1'b1;
`endif
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
      // Repeat timer only runs while sitting in HELD; anything else clears it.
      rpt_cnt       <= '0;
      rpt_first     <= 1'b1;
`endif
      case (state)
        KEY_RELEASED: begin
          if (!key_s) begin
            state <= KEY_PRESS_WAIT;
            cnt   <= '0;
          end
        end

        KEY_PRESS_WAIT: begin
          if (key_s) begin
            state <= KEY_RELEASED;
            cnt   <= '0;
          end else if (cnt >= DB_LAST) begin
            state       <= KEY_HELD;
            cnt         <= '0;
            key_lvl     <= 1'b0;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        KEY_HELD: begin
          if (key_s) begin
            state <= KEY_RELEASE_WAIT;
            cnt   <= '0;
          end
`ifdef KEY_DEBOUNCE_REPEAT_EN
          else if (rpt_cnt >= (rpt_first ? RD_LAST : RP_LAST)) begin
            press_pulse <= 1'b1;
            rpt_cnt     <= '0;
            rpt_first   <= 1'b0;
          end else begin
            rpt_cnt   <= rpt_cnt + 1'b1;
            rpt_first <= rpt_first;
          end
`endif
        end

        KEY_RELEASE_WAIT: begin
          if (!key_s) begin
            state <= KEY_HELD;
            cnt   <= '0;
          end else if (cnt >= DB_LAST) begin
            state         <= KEY_RELEASED;
            cnt           <= '0;
            key_lvl       <= 1'b1;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= KEY_RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: NUM_KEYS independent channels, active-low levels out,
// one-cycle press/release strobes.
// Optional feature macro: KEY_DEBOUNCE_REPEAT_EN (auto-repeat press pulses).
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS        = DEF_NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                iclk,
  input  logic                irst,
  input  logic [NUM_KEYS-1:0] ikey_raw,
  output logic [NUM_KEYS-1:0] okey,
  output logic [NUM_KEYS-1:0] opress,
  output logic [NUM_KEYS-1:0] orelease
);

  // One fully independent channel per key.
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk           (iclk),
      .rst           (irst),
      .key_raw       (ikey_raw[g]),
      .key_lvl       (okey[g]),
      .press_pulse   (opress[g]),
      .release_pulse (orelease[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus randomized key traffic,
// every cycle compared against a run-length reference model.
module tb_key_debounce;
  localparam int NK = 5;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          iclk = 1'b0;
  logic          irst = 1'b1;
  logic [NK-1:0] ikey_raw = '1;
  logic [NK-1:0] okey, opress, orelease;

  key_debounce #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .iclk(iclk), .irst(irst), .ikey_raw(ikey_raw),
    .okey(okey), .opress(opress), .orelease(orelease)
  );

  always #5 iclk = ~iclk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: raw delayed two edges; a level is accepted once the delayed
  // input has disagreed with it for DB+1 consecutive edges.  Repeat pulses
  // fall at hold ages RD, RD+RP, RD+2RP, ...
  logic [NK-1:0] m_s1, m_s2, m_deb, m_press, m_rel;
  int m_run[NK];
  int m_age[NK];

  task automatic model_step(input logic [NK-1:0] raw, input logic rst);
    logic [NK-1:0] v;
    if (rst) begin
      m_s1 = '1; m_s2 = '1; m_deb = '1; m_press = '0; m_rel = '0;
      for (int k = 0; k < NK; k++) begin m_run[k] = 0; m_age[k] = 0; end
    end else begin
      v = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      m_press = '0; m_rel = '0;
      for (int k = 0; k < NK; k++) begin
        if (v[k] != m_deb[k]) begin
          m_age[k] = 0;
          m_run[k]++;
          if (m_run[k] == DB + 1) begin
            m_deb[k] = v[k];
            m_run[k] = 0;
            if (v[k] == 1'b0) m_press[k] = 1'b1;
            else              m_rel[k]   = 1'b1;
          end
        end else begin
          if (m_deb[k] == 1'b0 && m_run[k] == 0) begin
            m_age[k]++;
            if (REP_EN && (m_age[k] == RD || (m_age[k] > RD && (m_age[k] - RD) % RP == 0)))
              m_press[k] = 1'b1;
          end else begin
            m_age[k] = 0;
          end
          m_run[k] = 0;
        end
      end
    end
  endtask

  // One clock: model sees the inputs present at the edge, outputs sampled #1 later.
  task automatic tick();
    logic [NK-1:0] r;
    logic          rs;
    r  = ikey_raw;
    rs = irst;
    @(posedge iclk);
    model_step(r, rs);
    #1;
    chk("okey",     32'(okey),     32'(m_deb));
    chk("opress",   32'(opress),   32'(m_press));
    chk("orelease", 32'(orelease), 32'(m_rel));
  endtask

  task automatic settle();
    ikey_raw = '1;
    repeat (14) tick();
  endtask

  int first, cnt, stray;
  logic [NK-1:0] val;
  int q[$];
  int exp_q[$];
  int hold[NK];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    irst = 1'b1;
    repeat (2) tick();
    chk("rst_okey", 32'(okey), 32'h1F);
    chk("rst_opress", 32'(opress), 32'h0);
    chk("rst_orelease", 32'(orelease), 32'h0);
    irst = 1'b0;

    // Clean press on key 1: accepted 6 edges after the raw edge is sampled
    ikey_raw[1] = 1'b0;
    first = -1; cnt = 0; stray = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (opress[1]) begin if (first < 0) first = i; cnt++; end
      if (((opress | orelease) & ~5'b00010) != '0) stray++;
    end
    chk("k1_press_cyc", 32'(first), 32'd6);
    chk("k1_press_cnt", 32'(cnt), 32'd1);
    chk("k1_stray", 32'(stray), 32'd0);
    chk("k1_okey", 32'(okey), 32'h1D);

    // Release key 1
    ikey_raw[1] = 1'b1;
    first = -1; cnt = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (orelease[1]) begin if (first < 0) first = i; cnt++; end
    end
    chk("k1_rel_cyc", 32'(first), 32'd6);
    chk("k1_rel_cnt", 32'(cnt), 32'd1);
    chk("k1_rel_okey", 32'(okey), 32'h1F);
    settle();

    // Bounce key 2 (2 low / 2 high) then hold high: nothing may change
    cnt = 0; stray = 0;
    for (int i = 0; i < 30; i++) begin
      ikey_raw[2] = (i < 20) ? logic'((i / 2) % 2) : 1'b1;
      tick();
      if ((opress | orelease) != '0) cnt++;
      if (okey != 5'h1F) stray++;
    end
    chk("bounce_pulses", 32'(cnt), 32'd0);
    chk("bounce_okey", 32'(stray), 32'd0);

    // Long hold on key 0: repeat schedule depends on the build
    q.delete(); exp_q.delete();
    exp_q.push_back(6);
    if (REP_EN) begin exp_q.push_back(16); exp_q.push_back(19); exp_q.push_back(22); end
    ikey_raw[0] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (opress[0]) q.push_back(i);
    end
    chk("rep_count", 32'(q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < q.size(); i++) chk("rep_cyc", 32'(q[i]), 32'(exp_q[i]));
    settle();

    // Reset while key 3 held: no release strobe, key re-debounced afterwards
    ikey_raw[3] = 1'b0;
    repeat (10) tick();
    chk("k3_held", 32'(okey), 32'h17);
    irst = 1'b1;
    tick();
    chk("rst_hold_okey", 32'(okey), 32'h1F);
    chk("rst_hold_rel", 32'(orelease), 32'h0);
    irst = 1'b0;
    first = -1; cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (orelease != '0) cnt++;
      if (okey[3] == 1'b0 && first < 0) first = i;
    end
    chk("k3_repress_cyc", 32'(first), 32'd6);
    chk("k3_no_release", 32'(cnt), 32'd0);
    settle();

    // Simultaneous press on keys 0 and 4
    ikey_raw[0] = 1'b0; ikey_raw[4] = 1'b0;
    first = -1; val = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (opress != '0 && first < 0) begin first = i; val = opress; end
    end
    chk("dual_cyc", 32'(first), 32'd6);
    chk("dual_val", 32'(val), 32'h11);
    settle();

    // Random traffic: short bounces mixed with long holds, rare resets
    for (int k = 0; k < NK; k++) hold[k] = $urandom_range(1, 6);
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (hold[k] == 0) begin
          ikey_raw[k] = ~ikey_raw[k];
          hold[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 40) : $urandom_range(1, 6);
        end
        hold[k]--;
      end
      irst = ($urandom_range(0, 299) == 0);
      tick();
    end
    irst = 1'b0;
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
